// File: rtl/cnn_fifo_pkg.sv
// Shared constants, depth field type and depth clamp helper for the CNN line FIFOs.
package cnn_fifo_pkg;

  localparam int unsigned CNN_PIX_W     = 8;
  localparam int unsigned CNN_CHANNELS  = 16;
  localparam int unsigned CNN_ROW_LEN   = 68;
  localparam int unsigned CNN_KERNEL    = 5;

  localparam int unsigned CNN_DATA_W    = CNN_PIX_W * CNN_CHANNELS;
  localparam int unsigned CNN_MAX_DEPTH = CNN_ROW_LEN - CNN_KERNEL + 1;
  localparam int unsigned CNN_DEPTH_W   = $clog2(CNN_MAX_DEPTH + 1);

  typedef logic [CNN_DEPTH_W-1:0] depth_t;

  // Zero is promoted to 1 so the output mux always has a real stage to select.
  function automatic int unsigned clamp_depth(input int unsigned req,
                                              input int unsigned max_depth);
    if (req == 0)         return 1;
    if (req > max_depth)  return max_depth;
    return req;
  endfunction

endpackage

// File: rtl/cnn_fifo_stage.sv
// One enable-gated storage word of the line FIFO with async active-low clear.
module cnn_fifo_stage #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/cnn_line_fifo.sv
// Stall-aware runtime-depth delay line feeding the CNN window generator.
// Optional build macro: CNN_LINE_FIFO_ZERO_FILL_EN (zero out_data until primed).
module cnn_line_fifo
  import cnn_fifo_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int MAX_DEPTH = 64,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [DEPTH_W-1:0] cfg_depth,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               primed,
  output logic [DEPTH_W-1:0] fill_cnt
);

  logic [DEPTH_W-1:0] r_depth_q;
  logic [DEPTH_W-1:0] r_fill_cnt;
  logic [DEPTH_W-1:0] w_cfg_clamped;
  logic               w_shift;
  logic               w_primed;
  logic [DATA_W-1:0]  w_sel;
  logic [DATA_W-1:0]  w_stage [MAX_DEPTH];

  // A flushed cycle drops its input, so the line must not shift either.
  assign w_shift       = in_valid & ~flush;
  assign w_cfg_clamped = DEPTH_W'(clamp_depth(32'(cfg_depth), MAX_DEPTH));
  assign w_primed      = (r_fill_cnt == r_depth_q);

  for (genvar g = 0; g < MAX_DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      cnn_fifo_stage #(.DATA_W(DATA_W)) u_stage (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_shift),
        .i_d   (in_data),
        .o_q   (w_stage[g])
      );
    end else begin : g_body
      cnn_fifo_stage #(.DATA_W(DATA_W)) u_stage (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_shift),
        .i_d   (w_stage[g-1]),
        .o_q   (w_stage[g])
      );
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (r_depth_q == DEPTH_W'(i + 1)) w_sel = w_stage[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_depth_q  <= DEPTH_W'(MAX_DEPTH);
      r_fill_cnt <= '0;
    end else if (flush) begin
      r_depth_q  <= w_cfg_clamped;
      r_fill_cnt <= '0;
    end else if (in_valid && (r_fill_cnt < r_depth_q)) begin
      r_fill_cnt <= r_fill_cnt + DEPTH_W'(1);
    end
  end

  assign primed    = w_primed;
  assign fill_cnt  = r_fill_cnt;
  assign out_valid = in_valid & w_primed & ~flush;

`ifdef CNN_LINE_FIFO_ZERO_FILL_EN
  assign out_data = w_primed ? w_sel : '0;
`else
  assign out_data = w_sel;
`endif

endmodule
